// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, IR codes, DMI op codes and field widths.
package jtag_pkg;
  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;
  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_BUSY  = 2'd3
  } dmi_op_e;
  localparam int IR_BITS       = 5;
  localparam int DTMCS_BITS    = 32;
  localparam int IDCODE_BITS   = 32;
  localparam int DMI_DATA_BITS = 32;
  localparam int DMI_OP_BITS   = 2;
  localparam logic [IR_BITS-1:0] IR_IDCODE  = 5'h01;
  localparam logic [IR_BITS-1:0] IR_DTMCS   = 5'h10;
  localparam logic [IR_BITS-1:0] IR_DMI     = 5'h11;
  localparam logic [IR_BITS-1:0] IR_BYPASS  = 5'h1f;
  localparam logic [IR_BITS-1:0] IR_CAPTURE = 5'b00001;
endpackage

// File: rtl/jtag_dtm_if.sv
// jtag_dtm_if: DMI request/response bus between the DTM (master) and the debug module (slave).
interface jtag_dtm_if #(parameter int DMI_ADDR_BITS = 6);
  localparam int DW = DMI_ADDR_BITS + jtag_pkg::DMI_DATA_BITS + jtag_pkg::DMI_OP_BITS;
  logic          dtm_req_valid;
  logic [DW-1:0] dtm_req_data;
  logic          dm_is_busy;
  logic [DW-1:0] dm_resp_data;
  modport master (output dtm_req_valid, dtm_req_data, input dm_is_busy, dm_resp_data);
  modport slave  (input dtm_req_valid, dtm_req_data, output dm_is_busy, dm_resp_data);
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP controller; state plus capture/shift/update strobes for IR and DR.
module jtag_tap_fsm import jtag_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);
  tap_state_e state_q, state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TAP_TLR;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TAP_TLR:    state_d = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_d = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_d = tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: state_d = tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_d = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_d = tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: state_d = tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
    endcase
  end
  assign state      = state_q;
  assign capture_ir = state_q == TAP_CAP_IR;
  assign shift_ir   = state_q == TAP_SH_IR;
  assign update_ir  = state_q == TAP_UPD_IR;
  assign capture_dr = state_q == TAP_CAP_DR;
  assign shift_dr   = state_q == TAP_SH_DR;
  assign update_dr  = state_q == TAP_UPD_DR;
endmodule

// File: rtl/jtag_dtm.sv
// jtag_dtm: RISC-V JTAG debug transport module (IR, IDCODE/DTMCS/DMI/BYPASS DRs, DMI request issue).
// Define JTAG_DTM_IDCODE_EN to implement the IDCODE register; otherwise IR 5'h01 acts as BYPASS.
module jtag_dtm import jtag_pkg::*; #(
  parameter int          DMI_ADDR_BITS = 6,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1e200a6d
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  jtag_dtm_if.master        dmi
);
  localparam int DW = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
`ifdef JTAG_DTM_IDCODE_EN
  localparam logic [IR_BITS-1:0] IR_RST = IR_IDCODE;
`else
  localparam logic [IR_BITS-1:0] IR_RST = IR_BYPASS;
`endif
  tap_state_e tap_state;
  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
  logic [IR_BITS-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DW-1:0] dr_sr_q, dr_sr_d, req_data_q, req_data_d, cap_val, shf_val, dmi_cap;
  logic [DTMCS_BITS-1:0] dtmcs_val;
  logic sticky_q, sticky_d, req_valid_q, req_valid_d;
  logic sel_dtmcs, sel_dmi, sel_idcode, busy, dmi_upd, req_go, set_sticky, clr_sticky;
  jtag_tap_fsm u_tap (
    .clk, .rst_n, .tms, .state(tap_state),
    .capture_ir, .shift_ir, .update_ir, .capture_dr, .shift_dr, .update_dr
  );
  always_comb begin
    sel_dtmcs  = ir_q == IR_DTMCS;
    sel_dmi    = ir_q == IR_DMI;
`ifdef JTAG_DTM_IDCODE_EN
    sel_idcode = ir_q == IR_IDCODE;
`else
    sel_idcode = 1'b0;
`endif
    busy       = sticky_q | dmi.dm_is_busy;
    dtmcs_val  = {14'b0, 2'b0, 1'b0, 3'd1, sticky_q ? 2'b11 : 2'b00, 6'(DMI_ADDR_BITS), 4'd1};
    dmi_cap    = {dmi.dm_resp_data[DW-1:2], busy ? DMI_OP_BUSY : dmi.dm_resp_data[1:0]};
    cap_val    = sel_dmi ? dmi_cap : sel_dtmcs ? DW'(dtmcs_val) : sel_idcode ? DW'(IDCODE_VALUE) : '0;
    // tdi enters at the top of the selected register's own length
    shf_val    = sel_dmi ? {tdi, dr_sr_q[DW-1:1]}
               : (sel_dtmcs | sel_idcode) ? DW'({tdi, dr_sr_q[DTMCS_BITS-1:1]}) : DW'(tdi);
    dr_sr_d    = capture_dr ? cap_val : shift_dr ? shf_val : dr_sr_q;
    ir_sr_d    = capture_ir ? IR_CAPTURE : shift_ir ? {tdi, ir_sr_q[IR_BITS-1:1]} : ir_sr_q;
    ir_d       = (tap_state == TAP_TLR) ? IR_RST : update_ir ? ir_sr_q : ir_q;
    dmi_upd    = update_dr & sel_dmi;
    req_go     = dmi_upd & (dr_sr_q[1:0] != DMI_OP_NOP) & ~busy;
    set_sticky = (capture_dr & sel_dmi & dmi.dm_is_busy) | (dmi_upd & busy);
    clr_sticky = update_dr & sel_dtmcs & (dr_sr_q[16] | dr_sr_q[17]);
    sticky_d   = set_sticky | (sticky_q & ~clr_sticky);
    req_valid_d = req_go;
    req_data_d  = req_go ? dr_sr_q : req_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q        <= IR_RST;
      ir_sr_q     <= '0;
      dr_sr_q     <= '0;
      sticky_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
    end else begin
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      dr_sr_q     <= dr_sr_d;
      sticky_q    <= sticky_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
    end
  end
  assign tdo               = shift_ir ? ir_sr_q[0] : shift_dr ? dr_sr_q[0] : 1'b0;
  assign dmi.dtm_req_valid = req_valid_q;
  assign dmi.dtm_req_data  = req_data_q;
endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: randomized self-checking bench for jtag_dtm against a scan-stream reference model.
module tb_jtag_dtm;
  import jtag_pkg::*;
`ifdef JTAG_DTM_IDCODE_EN
  localparam logic [4:0] RST_IR = 5'h01;
  localparam bit ID_EN = 1'b1;
`else
  localparam logic [4:0] RST_IR = 5'h1f;
  localparam bit ID_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, tms = 1'b1, tdi = 1'b0, tdo;
  jtag_dtm_if #(.DMI_ADDR_BITS(6)) dmi ();
  jtag_dtm #(.DMI_ADDR_BITS(6), .IDCODE_VALUE(32'h1e200a6d)) dut (
    .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .dmi(dmi)
  );
  always #5 clk = ~clk;
  int n_run = 0, n_fail = 0, req_cnt = 0, m_req_cnt = 0;
  logic [39:0] req_last = '0, m_req_data = '0;
  logic [4:0] m_ir = RST_IR;
  logic m_sticky = 1'b0;
  always @(negedge clk) if (dmi.dtm_req_valid === 1'b1) begin
    req_cnt++;
    req_last = dmi.dtm_req_data;
  end
  function automatic int reg_len(input logic [4:0] ir);
    if (ir == 5'h10 || (ir == 5'h01 && ID_EN)) return 32;
    if (ir == 5'h11) return 40;
    return 1;
  endfunction
  function automatic logic [39:0] cap_val(input logic [4:0] ir, input logic st, input logic b, input logic [39:0] resp);
    if (ir == 5'h10) return 40'({17'b0, 3'd1, st ? 2'd3 : 2'd0, 6'd6, 4'd1});
    if (ir == 5'h11) return {resp[39:2], (st | b) ? 2'd3 : resp[1:0]};
    if (ir == 5'h01 && ID_EN) return 40'(32'h1e200a6d);
    return '0;
  endfunction
  task automatic step(input logic t, input logic d, output logic o);
    @(negedge clk);
    o = tdo;
    tms = t;
    tdi = d;
  endtask
  task automatic goto_idle();
    logic o;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, o);
    step(1'b0, 1'b0, o);
    m_ir = RST_IR;
  endtask
  task automatic ir_scan(input logic [4:0] code, output logic [4:0] cap);
    logic o;
    step(1, 0, o); step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, code[i], o);
      cap[i] = o;
    end
    step(1, 0, o); step(0, 0, o);
    m_ir = code;
  endtask
  // The DR acts as a shift register fed by tdi: tdo shows {din, captured} LSB-first.
  task automatic dr_txn(input int n, input logic [127:0] din_in, output logic [127:0] got, output logic [127:0] exp);
    logic o, b;
    int len;
    logic [127:0] din, st, r, mask;
    mask = (128'd1 << n) - 128'd1;
    din = din_in & mask;
    len = reg_len(m_ir);
    b = dmi.dm_is_busy;
    st = (din << len) | 128'(cap_val(m_ir, m_sticky, b, dmi.dm_resp_data));
    if (m_ir == 5'h11 && b) m_sticky = 1'b1;
    r = st >> n;
    exp = st & mask;
    got = '0;
    step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], o);
      got[i] = o;
    end
    step(1, 0, o); step(0, 0, o); step(0, 0, o); step(0, 0, o);
    if (m_ir == 5'h10 && (r[16] | r[17])) m_sticky = 1'b0;
    if (m_ir == 5'h11) begin
      if (m_sticky | b) m_sticky = 1'b1;
      else if (r[1:0] != 2'd0) begin
        m_req_cnt++;
        m_req_data = r[39:0];
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    n_run++;
    if (dmi.dtm_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dmi.dtm_req_valid); end
    n_run++;
    if (dmi.dtm_req_data !== 40'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dmi.dtm_req_data); end
    n_run++;
    rst_n = 1'b1;
    goto_idle();
  endtask
  task automatic test_tlr_walk();
    logic o;
    logic [127:0] got, exp;
    for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 1'b1, o);
    goto_idle();
    dr_txn(32, 128'($urandom), got, exp);
    if (got !== exp) begin n_fail++; $display("FAIL idcode_after_tlr: got %h want %h", got[31:0], exp[31:0]); end
    n_run++;
    if (req_cnt !== m_req_cnt) begin n_fail++; $display("FAIL walk_no_req: got %0d want %0d", req_cnt, m_req_cnt); end
    n_run++;
  endtask
  task automatic test_dtmcs();
    logic [4:0] cap;
    logic [127:0] got, exp;
    ir_scan(5'h10, cap);
    if (cap !== 5'b00001) begin n_fail++; $display("FAIL ir_capture: got %b want 00001", cap); end
    n_run++;
    dr_txn(32, 128'($urandom & 32'hfffc_ffff), got, exp);
    if (got[31:0] !== 32'h00001061 || got !== exp) begin n_fail++; $display("FAIL dtmcs_read: got %h want %h", got[31:0], exp[31:0]); end
    n_run++;
  endtask
  task automatic test_dmi_write();
    logic [4:0] cap;
    logic [127:0] got, exp;
    dmi.dm_is_busy = 1'b0;
    dmi.dm_resp_data = {$urandom, $urandom};
    ir_scan(5'h11, cap);
    dr_txn(40, 128'h40_0000_0006, got, exp);
    if (got !== exp) begin n_fail++; $display("FAIL dmi_capture: got %h want %h", got[39:0], exp[39:0]); end
    n_run++;
    if (req_cnt !== m_req_cnt) begin n_fail++; $display("FAIL dmi_req_count: got %0d want %0d", req_cnt, m_req_cnt); end
    n_run++;
    if (req_last !== 40'h4000000006 || dmi.dtm_req_data !== m_req_data) begin
      n_fail++; $display("FAIL dmi_req_data: got %h want %h", req_last, 40'h4000000006);
    end
    n_run++;
    dr_txn(40, 128'h3f_1234_5678, got, exp);
    if (req_cnt !== m_req_cnt || dmi.dtm_req_data !== m_req_data) begin
      n_fail++; $display("FAIL dmi_nop: got %0d/%h want %0d/%h", req_cnt, dmi.dtm_req_data, m_req_cnt, m_req_data);
    end
    n_run++;
  endtask
  task automatic test_busy();
    logic [4:0] cap;
    logic [127:0] got, exp;
    dmi.dm_is_busy = 1'b1;
    dr_txn(40, 128'h20_0000_00aa, got, exp);
    if (got[1:0] !== 2'd3 || got !== exp) begin n_fail++; $display("FAIL busy_capture_op: got %h want %h", got[39:0], exp[39:0]); end
    n_run++;
    dmi.dm_is_busy = 1'b0;
    dr_txn(40, 128'h21_0000_0016, got, exp);
    if (req_cnt !== m_req_cnt) begin n_fail++; $display("FAIL busy_no_req: got %0d want %0d", req_cnt, m_req_cnt); end
    n_run++;
    ir_scan(5'h10, cap);
    dr_txn(32, 128'h0, got, exp);
    if (got[31:0] !== 32'h00001c61 || got !== exp) begin n_fail++; $display("FAIL busy_dmistat: got %h want %h", got[31:0], 32'h00001c61); end
    n_run++;
  endtask
  task automatic test_dmireset();
    logic [4:0] cap;
    logic [127:0] got, exp;
    dr_txn(32, 128'h0001_0000, got, exp);
    dr_txn(32, 128'h0, got, exp);
    if (got[31:0] !== 32'h00001061 || got !== exp) begin n_fail++; $display("FAIL dmireset_dmistat: got %h want %h", got[31:0], 32'h00001061); end
    n_run++;
    ir_scan(5'h11, cap);
    dr_txn(40, 128'h05_0000_000a, got, exp);
    if (req_cnt !== m_req_cnt || req_last !== m_req_data) begin
      n_fail++; $display("FAIL dmireset_req: got %0d/%h want %0d/%h", req_cnt, req_last, m_req_cnt, m_req_data);
    end
    n_run++;
  endtask
  task automatic test_tlr_sticky();
    logic [4:0] cap;
    logic [127:0] got, exp;
    dmi.dm_is_busy = 1'b1;
    dr_txn(40, 128'h0, got, exp);
    dmi.dm_is_busy = 1'b0;
    goto_idle();
    ir_scan(5'h10, cap);
    dr_txn(32, 128'h0, got, exp);
    if (got[31:0] !== 32'h00001c61 || got !== exp) begin n_fail++; $display("FAIL tlr_keeps_sticky: got %h want %h", got[31:0], exp[31:0]); end
    n_run++;
    if (dmi.dtm_req_data !== m_req_data) begin n_fail++; $display("FAIL tlr_keeps_data: got %h want %h", dmi.dtm_req_data, m_req_data); end
    n_run++;
    dr_txn(32, 128'h0002_0000, got, exp);
  endtask
  task automatic test_bypass();
    logic [4:0] cap;
    logic [127:0] got, exp;
    ir_scan(5'h05, cap);
    dr_txn(1, 128'h1, got, exp);
    dr_txn(4, 128'b1101, got, exp);
    if (got[3:0] !== 4'b1010 || got !== exp) begin n_fail++; $display("FAIL bypass_delay: got %b want %b", got[3:0], 4'b1010); end
    n_run++;
  endtask
  task automatic test_reset_mid_shift();
    logic [4:0] cap;
    logic o;
    logic [39:0] d;
    d = 40'h3a_dead_beee;
    ir_scan(5'h11, cap);
    step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < 20; i++) step(1'b0, d[i], o);
    @(negedge clk);
    rst_n = 1'b0;
    tms = 1'b1;
    @(negedge clk);
    if (tdo !== 1'b0 || dmi.dtm_req_data !== 40'h0) begin n_fail++; $display("FAIL midreset_state: got %b/%h want 0/0", tdo, dmi.dtm_req_data); end
    n_run++;
    rst_n = 1'b1;
    m_sticky = 1'b0;
    m_req_data = '0;
    goto_idle();
    repeat (3) step(0, 0, o);
    if (req_cnt !== m_req_cnt) begin n_fail++; $display("FAIL midreset_no_req: got %0d want %0d", req_cnt, m_req_cnt); end
    n_run++;
  endtask
  task automatic test_random();
    logic [4:0] cap, code;
    logic [127:0] got, exp, din;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: code = 5'h01;
        1: code = 5'h10;
        2, 3: code = 5'h11;
        default: code = 5'($urandom_range(0, 31));
      endcase
      if (code != m_ir || $urandom_range(0, 3) == 0) begin
        ir_scan(code, cap);
        if (cap !== 5'b00001) begin n_fail++; $display("FAIL rnd_ir_capture: got %b want 00001", cap); end
        n_run++;
      end
      dmi.dm_is_busy = ($urandom_range(0, 3) == 0);
      dmi.dm_resp_data = {$urandom, $urandom};
      din = {$urandom, $urandom, $urandom, $urandom};
      if (m_ir == 5'h10 && $urandom_range(0, 3) != 0) din[17:16] = 2'b00;
      dr_txn(reg_len(m_ir) + $urandom_range(0, 3), din, got, exp);
      if (got !== exp) begin n_fail++; $display("FAIL rnd_scan ir=%h: got %h want %h", m_ir, got[63:0], exp[63:0]); end
      n_run++;
      if (req_cnt !== m_req_cnt || dmi.dtm_req_data !== m_req_data) begin
        n_fail++; $display("FAIL rnd_req: got %0d/%h want %0d/%h", req_cnt, dmi.dtm_req_data, m_req_cnt, m_req_data);
      end
      n_run++;
    end
  endtask
  initial begin
    dmi.dm_is_busy = 1'b0;
    dmi.dm_resp_data = '0;
    test_reset();
    test_tlr_walk();
    test_dtmcs();
    test_dmi_write();
    test_busy();
    test_dmireset();
    test_tlr_sticky();
    test_bypass();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
